dcache_write_buffer: RTL and testbench

- FIFO write buffer between the dcache write-miss/writeback port (wr_* interface) and the AXI bridge data write port (data_wr_* interface).
- Absorbs dirty-line evictions and uncached stores so the dcache can continue a refill without waiting for the AXI write to complete.
- Flags read-after-write hazards so the dcache holds any read to a line that is still buffered.

---
 rtl/dcache_write_buffer.sv | 138 +++++++++++++
 tb/tb_dcache_write_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - FIFO write buffer between dcache write port and AXI bridge
//
// Purpose: queues dirty-line evictions and uncached stores so the dcache can
// keep refilling while the AXI write drains, and flags reads that hit a line
// still held in (or entering) the buffer.
//
// Ports:
//   clk, resetn                 core clock, asynchronous active-low reset
//   in_wr_req/type/addr/wstrb/data, in_wr_rdy
//                               write side from the dcache (push)
//   out_wr_req/type/addr/wstrb/data, out_wr_rdy
//                               head entry toward the AXI bridge (pop)
//   rd_req, rd_addr, rd_conflict
//                               read-after-write hazard check (combinational)
//   empty                       no entries buffered

module dcache_write_buffer #(
   parameter int DEPTH        = 4,
   parameter int LINE_WIDTH   = 128,
   parameter int OFFSET_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,

   input  logic                  in_wr_req,
   input  logic [2:0]            in_wr_type,
   input  logic [31:0]           in_wr_addr,
   input  logic [3:0]            in_wr_wstrb,
   input  logic [LINE_WIDTH-1:0] in_wr_data,
   output logic                  in_wr_rdy,

   output logic                  out_wr_req,
   output logic [2:0]            out_wr_type,
   output logic [31:0]           out_wr_addr,
   output logic [3:0]            out_wr_wstrb,
   output logic [LINE_WIDTH-1:0] out_wr_data,
   input  logic                  out_wr_rdy,

   input  logic                  rd_req,
   input  logic [31:0]           rd_addr,
   output logic                  rd_conflict,

   output logic                  empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [2:0]            ent_type  [DEPTH];
   logic [31:0]           ent_addr  [DEPTH];
   logic [3:0]            ent_wstrb [DEPTH];
   logic [LINE_WIDTH-1:0] ent_data  [DEPTH];
   logic [DEPTH-1:0]      ent_valid;

   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [CNT_W-1:0]      count;

   logic                  push;
   logic                  pop;
   logic                  line_hit;

   // The offset bits of the read address play no part in the line compare.
   logic                  unused_rd_offset;
   assign unused_rd_offset = ^rd_addr[OFFSET_WIDTH-1:0];

   // Acceptance is purely count-based: a full buffer refuses a write even if
   // the bridge pops in the same cycle, which keeps in_wr_rdy off the
   // out_wr_rdy timing path.
   assign in_wr_rdy  = (count != FULL_COUNT);
   assign out_wr_req = (count != '0);
   assign empty      = (count == '0);

   assign push = in_wr_req && in_wr_rdy;
   assign pop  = out_wr_req && out_wr_rdy;

   // Head entry drives the bridge directly from storage; no bypass, so a
   // pushed entry is visible the cycle after the push.
   assign out_wr_type  = ent_type[head];
   assign out_wr_addr  = ent_addr[head];
   assign out_wr_wstrb = ent_wstrb[head];
   assign out_wr_data  = ent_data[head];

   // Line-granular hazard check over every valid entry plus a write being
   // pushed this cycle. Sub-line writes are treated as touching the whole
   // line, which is conservative but never misses a hazard.
   always_comb begin
      line_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] &&
             (ent_addr[i][31:OFFSET_WIDTH] == rd_addr[31:OFFSET_WIDTH])) begin
            line_hit = 1'b1;
         end
      end
      if (push && (in_wr_addr[31:OFFSET_WIDTH] == rd_addr[31:OFFSET_WIDTH])) begin
         line_hit = 1'b1;
      end
      rd_conflict = rd_req && line_hit;
   end

   // Entries are cleared on reset so the head fields read as zero afterwards.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_type[i]  <= '0;
            ent_addr[i]  <= '0;
            ent_wstrb[i] <= '0;
            ent_data[i]  <= '0;
         end
         ent_valid <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else begin
         // push and pop never target the same slot: that would need the
         // buffer to be both empty (pop impossible) or full (push impossible).
         if (push) begin
            ent_type[tail]  <= in_wr_type;
            ent_addr[tail]  <= in_wr_addr;
            ent_wstrb[tail] <= in_wr_wstrb;
            ent_data[tail]  <= in_wr_data;
            ent_valid[tail] <= 1'b1;
            tail            <= tail + 1'b1;
         end
         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - self-checking bench for dcache_write_buffer

module tb_dcache_write_buffer;

   localparam int LW = 128;

   logic          clk;
   logic          resetn;
   logic          in_wr_req;
   logic [2:0]    in_wr_type;
   logic [31:0]   in_wr_addr;
   logic [3:0]    in_wr_wstrb;
   logic [LW-1:0] in_wr_data;
   logic          in_wr_rdy;
   logic          out_wr_req;
   logic [2:0]    out_wr_type;
   logic [31:0]   out_wr_addr;
   logic [3:0]    out_wr_wstrb;
   logic [LW-1:0] out_wr_data;
   logic          out_wr_rdy;
   logic          rd_req;
   logic [31:0]   rd_addr;
   logic          rd_conflict;
   logic          empty;

   dcache_write_buffer #(.DEPTH(4), .LINE_WIDTH(LW), .OFFSET_WIDTH(4)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_wr_req    (in_wr_req),
      .in_wr_type   (in_wr_type),
      .in_wr_addr   (in_wr_addr),
      .in_wr_wstrb  (in_wr_wstrb),
      .in_wr_data   (in_wr_data),
      .in_wr_rdy    (in_wr_rdy),
      .out_wr_req   (out_wr_req),
      .out_wr_type  (out_wr_type),
      .out_wr_addr  (out_wr_addr),
      .out_wr_wstrb (out_wr_wstrb),
      .out_wr_data  (out_wr_data),
      .out_wr_rdy   (out_wr_rdy),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_conflict  (rd_conflict),
      .empty        (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    wtype;
      logic [31:0]   addr;
      logic [3:0]    wstrb;
      logic [LW-1:0] data;
   } wr_t;

   typedef struct {
      logic        rreq;
      logic [31:0] raddr;
      logic        preq;
      logic [31:0] paddr;
      logic        exp_conflict;
   } conf_vec_t;

   wr_t       sb_q[$];
   int        checks = 0;
   int        passed = 0;
   conf_vec_t cvec[7];

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                           input logic [LW-1:0] d);
      in_wr_req   = 1'b1;
      in_wr_type  = t;
      in_wr_addr  = a;
      in_wr_wstrb = s;
      in_wr_data  = d;
   endtask

   // Scoreboard: a push seen at the negedge queues the expected entry; a pop
   // seen at the negedge compares the head against the oldest queued entry.
   always @(negedge clk) begin
      if (resetn) begin
         if (out_wr_req && out_wr_rdy) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_pop", 1'b1, 1'b0);
            end else begin
               wr_t e;
               e = sb_q.pop_front();
               check("sb_type",  {125'd0, out_wr_type}, {125'd0, e.wtype});
               check("sb_addr",  {96'd0, out_wr_addr},  {96'd0, e.addr});
               check("sb_wstrb", {124'd0, out_wr_wstrb}, {124'd0, e.wstrb});
               check("sb_data",  out_wr_data, e.data);
            end
         end
         if (in_wr_req && in_wr_rdy) begin
            wr_t n;
            n.wtype = in_wr_type;
            n.addr  = in_wr_addr;
            n.wstrb = in_wr_wstrb;
            n.data  = in_wr_data;
            sb_q.push_back(n);
         end
      end
   end

   initial begin
      logic [31:0] exp_addr;

      // rd_conflict vectors, applied with 0x2000_0030 buffered
      cvec[0] = '{1'b1, 32'h2000_003C, 1'b0, 32'h0, 1'b1};
      cvec[1] = '{1'b1, 32'h2000_0040, 1'b0, 32'h0, 1'b0};
      cvec[2] = '{1'b1, 32'h2000_0030, 1'b0, 32'h0, 1'b1};
      cvec[3] = '{1'b1, 32'h2000_002F, 1'b0, 32'h0, 1'b0};
      cvec[4] = '{1'b0, 32'h2000_0030, 1'b0, 32'h0, 1'b0};
      cvec[5] = '{1'b1, 32'h3000_0008, 1'b1, 32'h3000_0000, 1'b1};
      cvec[6] = '{1'b1, 32'h3000_0008, 1'b1, 32'h4000_0000, 1'b0};

      resetn      = 1'b0;
      in_wr_req   = 1'b0;
      in_wr_type  = 3'd0;
      in_wr_addr  = 32'd0;
      in_wr_wstrb = 4'd0;
      in_wr_data  = '0;
      out_wr_rdy  = 1'b0;
      rd_req      = 1'b1;
      rd_addr     = 32'd0;
      #1;
      check("rst_in_wr_rdy",   {127'd0, in_wr_rdy},   1);
      check("rst_out_wr_req",  {127'd0, out_wr_req},  0);
      check("rst_empty",       {127'd0, empty},       1);
      check("rst_rd_conflict", {127'd0, rd_conflict}, 0);
      tick();
      resetn = 1'b1;
      rd_req = 1'b0;
      tick();

      // single line write, drained the cycle it appears
      out_wr_rdy = 1'b1;
      drive_wr(3'd4, 32'h1C00_0040, 4'h0, 128'h0123);
      check("line_no_bypass", {127'd0, out_wr_req}, 0);
      tick();
      in_wr_req = 1'b0;
      check("line_out_req",  {127'd0, out_wr_req}, 1);
      check("line_out_addr", {96'd0, out_wr_addr}, 32'h1C00_0040);
      check("line_out_type", {125'd0, out_wr_type}, 3'd4);
      check("line_out_data", out_wr_data, 128'h0123);
      tick();
      check("line_empty_after", {127'd0, empty}, 1);

      // fill with the bridge stalled
      out_wr_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_wr(3'd2, 32'h100 + 32'(4 * i), 4'hF, {96'd0, $urandom()});
         check("fill_in_wr_rdy", {127'd0, in_wr_rdy}, 1);
         if (i > 0) check("fill_head_addr", {96'd0, out_wr_addr}, 32'h100);
         tick();
      end
      drive_wr(3'd2, 32'h110, 4'hF, 128'hDEAD);
      check("full_in_wr_rdy", {127'd0, in_wr_rdy}, 0);
      check("full_head_addr", {96'd0, out_wr_addr}, 32'h100);
      tick();
      check("full_in_wr_rdy_hold", {127'd0, in_wr_rdy}, 0);
      check("full_head_addr_hold", {96'd0, out_wr_addr}, 32'h100);
      in_wr_req = 1'b0;

      // drain in order
      out_wr_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_req",  {127'd0, out_wr_req}, 1);
         check("drain_addr", {96'd0, out_wr_addr}, 32'h100 + 32'(4 * i));
         tick();
         if (i == 0) check("drain_rdy_after_pop", {127'd0, in_wr_rdy}, 1);
      end
      check("drain_empty", {127'd0, empty}, 1);

      // steady push+pop at count 2 across pointer wraps
      out_wr_rdy = 1'b0;
      drive_wr(3'd2, 32'h200, 4'h3, 128'h11);
      tick();
      drive_wr(3'd1, 32'h204, 4'hC, 128'h22);
      tick();
      out_wr_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_wr(3'd0, 32'h300 + 32'(4 * i), 4'(1 << (i % 4)), {96'd0, $urandom()});
         exp_addr = (i < 2) ? 32'h200 + 32'(4 * i) : 32'h300 + 32'(4 * (i - 2));
         check("steady_addr",  {96'd0, out_wr_addr}, {96'd0, exp_addr});
         check("steady_rdy",   {127'd0, in_wr_rdy}, 1);
         check("steady_empty", {127'd0, empty}, 0);
         tick();
      end
      in_wr_req = 1'b0;
      tick();
      tick();
      check("steady_drained", {127'd0, empty}, 1);

      // read-after-write hazard table
      out_wr_rdy = 1'b0;
      drive_wr(3'd2, 32'h2000_0030, 4'hF, 128'h55);
      tick();
      in_wr_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         rd_req    = cvec[i].rreq;
         rd_addr   = cvec[i].raddr;
         in_wr_req = cvec[i].preq;
         in_wr_addr = cvec[i].paddr;
         #1;
         check($sformatf("conflict_vec%0d", i), {127'd0, rd_conflict},
               {127'd0, cvec[i].exp_conflict});
         in_wr_req = 1'b0;
      end
      rd_req  = 1'b1;
      rd_addr = 32'h2000_0038;
      out_wr_rdy = 1'b1;
      tick();
      check("conflict_after_pop", {127'd0, rd_conflict}, 0);
      rd_req = 1'b0;

      // asynchronous reset with entries held
      out_wr_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_wr(3'd2, 32'h500 + 32'(4 * i), 4'hF, 128'h77);
         tick();
      end
      in_wr_req = 1'b0;
      check("pre_rst_req", {127'd0, out_wr_req}, 1);
      #1;
      resetn = 1'b0;
      #1;
      check("async_rst_req",   {127'd0, out_wr_req}, 0);
      check("async_rst_empty", {127'd0, empty}, 1);
      check("async_rst_rdy",   {127'd0, in_wr_rdy}, 1);
      sb_q.delete();
      tick();
      resetn = 1'b1;
      out_wr_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_no_stale", {127'd0, out_wr_req}, 0);
      end

      check("sb_all_drained", 128'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
